lsu_byte_serial: RTL
====================

Name: lsu_byte_serial

Overview:
- Multi-cycle load/store unit sitting directly downstream of the hart's execute logic.
- Takes one memory request per handshake: an effective address, a funct3 and, for stores, the store value.
- Performs the access one byte per cycle against a byte-wide synchronous RAM and returns the extended load result or a store completion.
- Replaces the hart's single-cycle direct RAM indexing so the data memory can become a real inferred block RAM.

Parameters:
- XLEN, 32, data/address width of the request interface.
- ADDR_WIDTH, 8, byte-address width of the RAM (depth 2**ADDR_WIDTH bytes).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (IDLE only)
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  XLEN  effective byte address
- req_wdata  in  XLEN  store value (rs2)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load data; 0 for stores and faults
- resp_fault  out  1  request rejected, no memory effect
- mem_addr  out  ADDR_WIDTH  RAM byte address
- mem_re  out  1  read strobe; data returned on mem_rdata the next cycle
- mem_we  out  1  write strobe for one byte
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, 1-cycle synchronous latency

Behaviour:
- Reset: reset is synchronous, active-high; clock is clock.
  - After the reset edge: state IDLE, req_ready=1, resp_valid=0, resp_fault=0, resp_rdata=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset asserted mid-operation aborts it: no further mem_we/mem_re after that edge, and no resp_valid for the aborted request. Bytes already written stay written.
- Accept: a request is accepted when req_valid && req_ready at a rising edge. All request fields are latched at that edge. Inputs are ignored outside IDLE.
- Size: funct3[1:0] 00 → 1 byte, 01 → 2 bytes, 10 → 4 bytes.
- Fault conditions, checked at accept:
  - Load with funct3 not in {000, 001, 010, 100, 101}.
  - Store with funct3 not in {000, 001, 010}.
  - req_addr[XLEN-1:ADDR_WIDTH] != 0.
  - req_addr + nbytes - 1 > 2**ADDR_WIDTH - 1. Addresses never wrap.
  - On fault: IDLE → RESP with no memory strobes; resp_fault=1, resp_rdata=0.
- Misaligned in-range accesses are legal; bytes are accessed individually, little-endian.
- FSM:
  - IDLE: on accept with fault → RESP. Store → STORE, i=0. Load → LOAD, i=0.
  - STORE: mem_we=1, mem_addr=base+i, mem_wdata=wdata[8i+7:8i]. i increments each cycle. After byte nbytes-1 → RESP. Exactly nbytes write cycles.
  - LOAD: mem_re=1, mem_addr=base+i. On each cycle with i≥1, capture mem_rdata into byte i-1 of the assembly register. After issuing byte nbytes-1 → DRAIN.
  - DRAIN: capture the last byte, then compute the extension into resp_rdata → RESP.
    - LB: sign-extend from bit 7. LH: sign-extend from bit 15.
    - LBU/LHU: zero-extend. LW: unchanged.
  - RESP: resp_valid=1 for exactly this cycle, resp_fault as latched → IDLE. req_ready=0 here, so back-to-back requests are accepted the cycle after RESP.
- Latency from accept edge to the resp_valid cycle: store = nbytes+1 cycles, load = nbytes+2 cycles, fault = 1 cycle.
- Combined timing: mem_re and mem_we are never both 1. Strobes are 0 in IDLE, DRAIN and RESP.
- resp_rdata and resp_fault hold their values until the next RESP. They are meaningful only when resp_valid=1.

Test Plan:
- SW 0x1234_560A at 0x60 → mem_we on 4 consecutive cycles with (0x60,0x0A), (0x61,0x56), (0x62,0x34), (0x63,0x12). resp_valid 5 cycles after accept, resp_rdata=0, fault=0.
- LW 0x60 after the store above → mem_re at 0x60..0x63 on 4 cycles, resp_valid 6 cycles after accept, resp_rdata=0x1234_560A.
- RAM[0x70]=0xFF: LB 0x70 → 0xFFFF_FFFF; LBU → 0x0000_00FF. RAM[0x71..0x72]=0x80,0x7F: misaligned LH 0x71 → 0x0000_7F80. RAM[0x72]=0x80: LHU 0x72 → 0x0000_0080 (RAM[0x73]=0).
- Faults → resp_fault=1 one cycle after accept, no mem_re/mem_we ever asserted:
  - load funct3=011 at 0x10
  - SW with funct3=100
  - LW at 0xFE (crosses top of RAM, ADDR_WIDTH=8)
  - LB at 0x100
- Reset asserted after the 2nd write cycle of SW 0xAABBCCDD at 0x20 → RAM 0x20=0xDD, 0x21=0xCC only, no resp_valid, req_ready=1 the cycle after the reset edge. A following LW accepted normally.
- req_valid held high continuously with alternating SB/LBU → each accept occurs only in IDLE, one cycle after the previous RESP. No request is lost or accepted twice.

Source files
------------

// File: rtl/lsu_byte_serial.sv
// Byte-serial load/store unit: executes one RISC-V load or store as a sequence of
// single-byte accesses against a byte-wide synchronous RAM with 1-cycle read latency.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// STORE | one mem_we byte per cycle, byte idx of the latched store value
// LOAD  | one mem_re per cycle; the byte requested last cycle is captured
// DRAIN | capture the final read byte and extend it into resp_rdata
// RESP  | one-cycle resp_valid pulse, then back to IDLE
module lsu_byte_serial #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_fault,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  typedef enum logic [2:0] {IDLE, STORE, LOAD, DRAIN, RESP} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t          state;
  logic [1:0]      idx;
  logic [1:0]      last;
  logic [2:0]      funct3;
  logic [3:0][7:0] wbytes;
  logic [3:0][7:0] lbytes;
  logic [3:0][7:0] lfull;
  logic [1:0]      req_last;
  logic            req_legal;
  logic            req_fault;
  logic [ADDR_WIDTH:0] req_end;

  function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [31:0] w);
    logic [XLEN-1:0] r;
    case (f3)
      3'b000:  r = XLEN'($signed(w[7:0]));
      3'b001:  r = XLEN'($signed(w[15:0]));
      3'b100:  r = XLEN'(w[7:0]);
      3'b101:  r = XLEN'(w[15:0]);
      default: r = XLEN'($signed(w));
    endcase
    return r;
  endfunction

  // The last byte index is checked against the RAM top; the carry bit means it ran past it.
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   req_last = 2'd0;
      2'b01:   req_last = 2'd1;
      default: req_last = 2'd3;
    endcase
    if (req_is_store)
      req_legal = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
    else
      req_legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    req_end   = {1'b0, req_addr[ADDR_WIDTH-1:0]} + {{(ADDR_WIDTH-1){1'b0}}, req_last};
    req_fault = !req_legal || (req_addr[XLEN-1:ADDR_WIDTH] != '0) || req_end[ADDR_WIDTH];
    lfull       = lbytes;
    lfull[last] = mem_rdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      idx        <= '0;
      last       <= '0;
      funct3     <= '0;
      wbytes     <= '0;
      lbytes     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            funct3    <= req_funct3;
            last      <= req_last;
            idx       <= '0;
            wbytes    <= req_wdata[31:0];
            lbytes    <= '0;
            if (req_fault) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= '0;
            end else if (req_is_store) begin
              state     <= STORE;
              mem_we    <= 1'b1;
              mem_addr  <= req_addr[ADDR_WIDTH-1:0];
              mem_wdata <= req_wdata[7:0];
            end else begin
              state    <= LOAD;
              mem_re   <= 1'b1;
              mem_addr <= req_addr[ADDR_WIDTH-1:0];
            end
          end
        end
        STORE: begin
          if (idx == last) begin
            mem_we     <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
          end else begin
            idx       <= idx + 2'd1;
            mem_addr  <= mem_addr + ADDR_ONE;
            mem_wdata <= wbytes[idx + 2'd1];
          end
        end
        LOAD: begin
          // mem_rdata now carries the byte requested in the previous cycle
          if (idx != 2'd0) lbytes[idx - 2'd1] <= mem_rdata;
          if (idx == last) begin
            mem_re <= 1'b0;
            state  <= DRAIN;
          end else begin
            idx      <= idx + 2'd1;
            mem_addr <= mem_addr + ADDR_ONE;
          end
        end
        DRAIN: begin
          resp_rdata <= extend(funct3, lfull);
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mem_re    <= 1'b0;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule
